// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-port-per-direction RAM.
// Tracks pointers/occupancy, issues RAM strobes combinationally and returns popped words one cycle later.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               pop,
  input  logic               clear,
  output logic               full,
  output logic               empty,
  output logic [A_WIDTH:0]   count,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  output logic               overflow,
  output logic               underflow,
  output logic               en_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               en_read,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);

  localparam logic [A_WIDTH:0] DEPTH_CNT = (A_WIDTH + 1)'(1 << A_WIDTH);

  logic [A_WIDTH-1:0] wr_ptr_reg;
  logic [A_WIDTH-1:0] rd_ptr_reg;
  logic [A_WIDTH:0]   count_reg;
  logic [A_WIDTH:0]   count_next;
  logic               overflow_reg;
  logic               underflow_reg;
  logic               out_valid_reg;
  logic [D_WIDTH-1:0] out_data_hold_reg;
  logic [A_WIDTH-1:0] addr_w_hold_reg;
  logic [A_WIDTH-1:0] addr_r_hold_reg;
  logic [D_WIDTH-1:0] data_w_hold_reg;
  logic               push_acc;
  logic               pop_acc;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // rst_n gates the strobes so they drop immediately on an asynchronous reset.
  assign push_acc = rst_n && !clear && push && (!full || pop);
  assign pop_acc  = rst_n && !clear && pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_data_hold_reg <= '0;
      addr_w_hold_reg   <= '0;
      addr_r_hold_reg   <= '0;
      data_w_hold_reg   <= '0;
    end else begin
      out_valid_reg <= pop_acc;
      if (out_valid_reg) begin
        out_data_hold_reg <= data_read;
      end
      if (push_acc) begin
        addr_w_hold_reg <= wr_ptr_reg;
        data_w_hold_reg <= in_data;
      end
      if (pop_acc) begin
        addr_r_hold_reg <= rd_ptr_reg;
      end
      if (clear) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (push_acc) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop_acc) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        count_reg     <= count_next;
        overflow_reg  <= overflow_reg | (push & ~push_acc);
        underflow_reg <= underflow_reg | (pop & ~pop_acc);
      end
    end
  end

  // The RAM registers its read, so data_read is valid exactly while out_valid is high.
  assign out_valid     = out_valid_reg;
  assign out_data      = out_valid_reg ? data_read : out_data_hold_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;
  assign en_write      = push_acc;
  assign write_enable  = push_acc;
  assign address_write = push_acc ? wr_ptr_reg : addr_w_hold_reg;
  assign data_write    = push_acc ? in_data : data_w_hold_reg;
  assign en_read       = pop_acc;
  assign address_read  = pop_acc ? rd_ptr_reg : addr_r_hold_reg;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: queue-based reference model, behavioural RAM,
// and a monitor that pops expected words whenever out_valid is seen.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [15:0] in_data = '0;
  logic        pop = 1'b0;
  logic        clear = 1'b0;
  logic        full, empty, out_valid, overflow, underflow;
  logic [4:0]  count;
  logic [15:0] out_data, data_write;
  logic        en_write, write_enable, en_read;
  logic [3:0]  address_write, address_read;
  logic [15:0] data_read = '0;

  ram_fifo_ctrl #(.D_WIDTH(16), .A_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .in_data(in_data), .pop(pop), .clear(clear),
    .full(full), .empty(empty), .count(count), .out_data(out_data), .out_valid(out_valid),
    .overflow(overflow), .underflow(underflow), .en_write(en_write), .write_enable(write_enable),
    .address_write(address_write), .data_write(data_write), .en_read(en_read),
    .address_read(address_read), .data_read(data_read)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, contents survive reset.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (en_write && write_enable) mem[address_write] <= data_write;
    if (en_read) data_read <= mem[address_read];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; int due; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [15:0] mq[$];
  bit          m_ovf, m_udf;
  logic [3:0]  m_wa, m_ra, last_wa, last_ra;
  logic [15:0] last_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 0; m_udf = 0;
    m_wa = '0; m_ra = '0;
    last_wa = '0; last_ra = '0; last_wd = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && started) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_spurious", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          $display("pop  data=%04h expected=%04h cycle=%0d", out_data, e.d, cyc);
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_latency", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("out_valid_missing", 32'(out_valid), 32'(1));
      end
    end
  end

  task automatic step(input bit p, input logic [15:0] d, input bit q_pop, input bit c);
    bit pok, rok;
    exp_t e;
    @(negedge clk);
    push = p; in_data = d; pop = q_pop; clear = c;
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == 16));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    rok = q_pop && !c && mq.size() > 0;
    pok = p && !c && (mq.size() < 16 || q_pop);
    if (pok) begin last_wa = m_wa; last_wd = d; end
    if (rok) last_ra = m_ra;
    check("en_write", 32'(en_write), 32'(pok));
    check("write_enable", 32'(write_enable), 32'(pok));
    check("en_read", 32'(en_read), 32'(rok));
    check("address_write", 32'(address_write), 32'(last_wa));
    check("data_write", 32'(data_write), 32'(last_wd));
    check("address_read", 32'(address_read), 32'(last_ra));
    if (c) begin
      mq.delete();
      m_ovf = 0; m_udf = 0;
      m_wa = '0; m_ra = '0;
    end else begin
      if (rok) begin
        e.d = mq.pop_front();
        e.due = cyc + 1;
        exp_q.push_back(e);
        m_ra = m_ra + 4'd1;
      end
      if (pok) begin
        mq.push_back(d);
        m_wa = m_wa + 4'd1;
      end
      if (p && !pok) m_ovf = 1;
      if (q_pop && !rok) m_udf = 1;
    end
  endtask

  task automatic check_reset_values();
    check("rst_count", 32'(count), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_underflow", 32'(underflow), 32'(0));
    check("rst_en_write", 32'(en_write), 32'(0));
    check("rst_write_enable", 32'(write_enable), 32'(0));
    check("rst_en_read", 32'(en_read), 32'(0));
    check("rst_address_write", 32'(address_write), 32'(0));
    check("rst_address_read", 32'(address_read), 32'(0));
    check("rst_data_write", 32'(data_write), 32'(0));
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 2);
    end
  endtask

  initial begin
    model_reset();
    // Push held high during reset: strobes must stay 0.
    push = 1'b1; pop = 1'b1; in_data = 16'h5555;
    #3;
    check_reset_values();
    push = 1'b0; pop = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    started = 1;

    // Ordered burst of 8 then drain
    for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    // Fill, overflow, simultaneous push/pop while full
    for (int i = 0; i < 16; i++) step(1, 16'h2000 + 16'(i), 0, 0);
    step(1, 16'hDEAD, 0, 0);
    step(1, 16'hABCD, 1, 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, '0, 1, 0);

    // Pop when empty, then push+pop when empty
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(1, 16'h3333, 1, 0);
    step(0, '0, 0, 0);

    // Clear wins over push/pop
    step(1, 16'h4444, 1, 1);
    step(0, '0, 0, 0);

    // Wrap-around: addresses 12..15,0..3
    for (int i = 0; i < 12; i++) step(1, 16'h5000 + 16'(i), 0, 0);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 16'h6000 + 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    random_phase(300);

    // Asynchronous reset mid-burst, off any clock edge
    for (int i = 0; i < 6; i++) step(1, 16'(16'h7000 + i), i > 2, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #0.5;
    check_reset_values();
    model_reset();
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    #0.5;
    rst_n = 1'b1;

    random_phase(300);
    for (int i = 0; i < 18; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 16, data word width.
REQ-002 Parameter A_WIDTH, default 4, RAM address width; depth DEPTH = 2^A_WIDTH (16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 push  input  1  write request; in_data is stored when accepted.
REQ-006 in_data  input  D_WIDTH  write data.
REQ-007 pop  input  1  read request.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 empty  output  1  high when count == 0.
REQ-010 count  output  A_WIDTH+1  number of stored words, 0..DEPTH.
REQ-011 out_data  output  D_WIDTH  popped word, qualified by out_valid.
REQ-012 out_valid  output  1  one-cycle pulse marking out_data valid.
REQ-013 overflow  output  1  sticky; set by a rejected push.
REQ-014 underflow  output  1  sticky; set by a rejected pop.
REQ-015 clear  input  1  synchronous flush; empties the queue and clears the sticky flags.
REQ-016 en_write, write_enable  output  1 each  RAM write-port strobes.
REQ-017 address_write  output  A_WIDTH  RAM write address.
REQ-018 data_write  output  D_WIDTH  RAM write data.
REQ-019 en_read  output  1  RAM read-port enable.
REQ-020 address_read  output  A_WIDTH  RAM read address.
REQ-021 data_read  input  D_WIDTH  RAM read data; registered by the RAM, valid the edge after en_read.

Function
REQ-022 Accept conditions: push is accepted when (push && !full) || (push && pop && full); pop is accepted when pop && !empty.
REQ-023 Accepted push, combinational in the same cycle:
- en_write = 1, write_enable = 1
- address_write = wr_ptr, data_write = in_data
- wr_ptr increments at the edge.
REQ-024 Accepted pop, combinational in the same cycle:
- en_read = 1, address_read = rd_ptr
- rd_ptr increments at the edge.
REQ-025 RAM strobes are 0 in any cycle without an accepted push or pop; address and data outputs then hold their last driven values.
REQ-026 Pointers are A_WIDTH bits and wrap DEPTH-1 -> 0 with no gap or stall.
REQ-027 count update per cycle: +1 on push only; -1 on pop only; unchanged on both accepted or neither.
REQ-028 Read latency:
- out_valid = 1 exactly one cycle after an accepted pop, with out_data = data_read.
- out_valid = 0 otherwise; out_data holds its last value.
REQ-029 Back-to-back pops yield out_valid high on consecutive cycles in FIFO order.
REQ-030 Simultaneous push and pop when empty: push accepted, pop rejected and underflow set; the word is not bypassed.
REQ-031 Simultaneous push and pop when full: both accepted; count stays DEPTH.
REQ-032 Rejected push or pop: RAM strobes stay 0, pointers and count unchanged, the matching sticky flag is set at the edge.
REQ-033 clear has priority over push and pop in the same cycle:
- pointers, count, overflow and underflow go to 0
- no RAM strobe that cycle; out_valid = 0 the next cycle.

Reset
REQ-034 While rst_n = 0, asynchronously, independent of clk:
- wr_ptr, rd_ptr, count, out_data = 0; out_valid, overflow, underflow = 0
- full = 0, empty = 1
- en_write, write_enable, en_read = 0; address_write, address_read, data_write = 0.
REQ-035 Reset asserted mid-operation discards all queued data and any pending out_valid; RAM contents are not cleared.
REQ-036 The first push is accepted on the first rising edge at which rst_n = 1.

Verification
REQ-037 Push 8 words 0x1000..0x1007, then pop 8 -> out_valid pulses return 0x1000..0x1007 in order, each one cycle after its pop; count ends 0, empty = 1.
REQ-038 Push 16 words -> full = 1, count = 16; a 17th push -> overflow = 1, count stays 16, en_write = 0 that cycle.
REQ-039 Pop when empty -> underflow = 1, en_read = 0, out_valid stays 0.
REQ-040 Wrap-around: push 12, pop 12, then push 8 -> address_write sequence 12,13,14,15,0,1,2,3; popping returns the data intact.
REQ-041 When full, push 0xABCD and pop together -> count stays 16; out_valid returns the oldest word; 0xABCD written at the address just freed.
REQ-042 rst_n low for 1 ns mid-burst, off any clock edge -> all outputs at reset values immediately; empty = 1, count = 0.
